// File: rtl/sort_pkg.sv
// Shared definitions for the timsort8 engine and the blocks that feed it:
// lane count, arbiter state encoding and lane pack/unpack helpers.
package sort_pkg;

    localparam int SORT_LANES = 8;
    localparam int SORT_W     = 32;

    typedef logic [SORT_W-1:0] sort_word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } arb_state_t;

    // Lane k lands in bits [k*SORT_W +: SORT_W], matching the in0..in7 order.
    function automatic logic [SORT_LANES*SORT_W-1:0] pack_lanes(input sort_word_t lanes [SORT_LANES]);
        logic [SORT_LANES*SORT_W-1:0] bus;
        bus = '0;
        for (int k = 0; k < SORT_LANES; k++) begin
            bus[k*SORT_W +: SORT_W] = lanes[k];
        end
        return bus;
    endfunction

    function automatic sort_word_t lane_word(input logic [SORT_LANES*SORT_W-1:0] bus, input int k);
        return bus[k*SORT_W +: SORT_W];
    endfunction

endpackage

// File: rtl/sort_job_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req at or after ptr,
// wrapping modulo N. Reusable by any N-way resource arbiter.
module rr_pick #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt_idx     = PW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sort_job_arbiter.sv
// Shares one timsort8 engine between NREQ requesters: round-robin grant,
// one job in flight, timeout abort, result returned over valid/ready.
module sort_job_arbiter
    import sort_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*SORT_LANES*W-1:0] req_data,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [SORT_LANES*W-1:0]    rsp_data,
    output logic                       rsp_err,
    output logic                       srt_start,
    output logic [SORT_LANES*W-1:0]    srt_in,
    input  logic                       srt_done,
    input  logic [SORT_LANES*W-1:0]    srt_out
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int DW = SORT_LANES * W;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [DW-1:0] opnd_q, opnd_d;
    logic [DW-1:0] res_q, res_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.N(NREQ)) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        opnd_d    = opnd_q;
        res_d     = res_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        srt_start = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by rst_n so no accept is advertised on a cycle that is being reset.
                if (pick_any && rst_n) begin
                    req_ready = pick_oh;
                    opnd_d    = req_data[int'(pick_idx)*DW +: DW];
                    gnt_d     = pick_idx;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                srt_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (srt_done) begin
                    res_d   = srt_out;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    rr_ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments; operand and result registers are reset because their zero value shows on the ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            opnd_q   <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            opnd_q   <= opnd_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign srt_in   = opnd_q;
    assign rsp_data = res_q;
    assign rsp_err  = err_q;

endmodule

// File: doc/sort_job_arbiter.md
# sort_job_arbiter

Shares one `timsort8` sorting engine between `NREQ` independent requesters. The arbiter grants requesters round-robin and latches the granted requester's eight operands. It pulses the engine's start input, waits for done or a timeout, then returns the sorted words to the same requester over a valid/ready response channel. It sits between the client blocks and a single `timsort8` instance, and owns that engine's `start` and `in0..in7` inputs.

## Interface
- `NREQ`, default 2: number of requesters (2..4).
- `W`, default 32: operand width (matches `timsort8`).
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before abort (1..65535).

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  NREQ: requester r has a job.
- `req_ready`  out  NREQ: one-hot; job of requester r accepted this cycle.
- `req_data`  in  NREQ*8*W: requester r's operands at bits [r*8W +: 8W]. Lane k (bits [k*W +: W]) maps to `in<k>`.
- `rsp_valid`  out  NREQ: one-hot; result pending for requester r.
- `rsp_ready`  in  NREQ: requester r takes the result.
- `rsp_data`  out  8*W: sorted words; lane 0 holds the smallest value.
- `rsp_err`  out  1: the result is a timeout abort; qualified by `rsp_valid`.
- `srt_start`  out  1: to `timsort8.start`.
- `srt_in`  out  8*W: to `timsort8.in0..in7`, packed as in `req_data`.
- `srt_done`  in  1: from `timsort8.done`.
- `srt_out`  in  8*W: from `timsort8.out0..out7`, packed.

## Operation
- The state machine has five states: IDLE, LOAD, START, WAIT and RESP.
- IDLE:
  - If any `req_valid` is set, select the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Assert the winner's `req_ready` for exactly one cycle.
  - Latch the winner's `req_data` into the operand register, record its index in `gnt`, and go to LOAD.
- LOAD: the operand register already drives `srt_in`. Go to START; this gives the engine one setup cycle.
- START: drive `srt_start`=1 for exactly one cycle, clear the timeout counter, and go to WAIT.
- WAIT:
  - `srt_done` is sampled only in WAIT, so a done level left high from a previous job is ignored during START.
  - On `srt_done`=1, capture `srt_out` into the result register, set `err`=0, and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT, zero the result register, set `err`=1, and go to RESP.
- RESP:
  - Hold `rsp_valid[gnt]`=1 with stable `rsp_data` and `rsp_err` until `rsp_ready[gnt]`=1.
  - On that handshake, set `rr_ptr` = (gnt+1) mod NREQ and return to IDLE.
  - `rsp_ready` on non-granted bits is ignored.
- `srt_in` stays stable from LOAD until the next grant.
- The engine is never restarted while in WAIT. The arbiter holds one job at a time, and there is no preemption.
- A requester that drops `req_valid` before its grant simply loses that arbitration. No error is raised.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it cannot wrap.

## Timing
- Reset values:
  - State = IDLE; `rr_ptr`=0; `gnt`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `srt_start`=0.
  - `rsp_data`=0, `srt_in`=0.
- `rst_n` low in any state, including mid-WAIT, returns the block to IDLE on the next edge.
  - Any in-flight job is dropped, and no response is issued for it.
  - The engine is left running; its next `srt_done` is ignored because it arrives outside WAIT.
- With the engine idle, the accept (`req_ready`) edge is followed by `srt_start` exactly 2 cycles later.
- `rsp_valid` rises in the cycle after the WAIT edge that saw `srt_done`.
- End-to-end latency is 4 + D cycles, where D is the engine's cycles from start to done.
- Back-to-back jobs:
  - The `rsp_ready` handshake cycle returns to IDLE.
  - The next grant can occur in the cycle after that handshake.
  - This gives a minimum of 1 idle cycle between a response and the next accept.
- Simultaneous `req_valid` from all requesters: grants rotate strictly r0, r1, … in round-robin order.

## Structure
- Shared package `sort_pkg`:
  - `SORT_LANES`=8.
  - The state enum `arb_state_t` (IDLE, LOAD, START, WAIT, RESP).
  - The lane pack/unpack helper functions, which `timsort8` wrappers also use.
- One sub-module, `rr_pick`: a combinational round-robin first-set-bit selector over NREQ bits, taking a start pointer. It is reusable by other resource arbiters.
- `timsort8` is instantiated by the parent, not inside this block.

## Test plan
- Single job from r0 with inputs 56,12,89,33,7,98,45,21: `rsp_valid[0]` is asserted with lanes 7,12,21,33,45,56,89,98 and `rsp_err`=0, and `srt_start` fires exactly once.
- r0 and r1 both valid with distinct data, held for 3 jobs each: grants go r0,r1,r0,r1,r0,r1, and each response carries that requester's own sorted data.
- Stub engine that never asserts done, with TIMEOUT=16: the response arrives with `rsp_err`=1 and `rsp_data`=0, and the next job completes normally.
- `rsp_ready` held low for 20 cycles in RESP: `rsp_data` stays stable, no new `req_ready` is issued, and the data is accepted on the first ready.
- `rst_n` pulsed low mid-WAIT: all outputs return to their reset values, the late `srt_done` does not produce a response, and a fresh job then sorts correctly.
- Stub engine that holds done high between jobs: the second job still waits for the stub's new done, because done is only sampled in WAIT.
